// File: rtl/axi_rd_arb_pkg.sv
//============================================================================
// axi_rd_arb_pkg: shared widths, FSM state type and payload layout helpers.
// Rev 1.0
//============================================================================
`default_nettype none

package axi_rd_arb_pkg;

  localparam int ADDR_W  = 40;
  localparam int DATA_W  = 128;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // AR payload: {araddr, arlen, arsize, arburst, arid}; id occupies the LSBs.
  function automatic int ar_w(input int id_w);
    return ADDR_W + LEN_W + SIZE_W + BURST_W + id_w;
  endfunction

  // R payload: {rdata, rresp, rlast, rid}; rlast sits just above rid.
  function automatic int r_w(input int id_w);
    return DATA_W + RESP_W + 1 + id_w;
  endfunction

  function automatic int r_last_bit(input int id_w);
    return id_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_arb_cnt.sv
//============================================================================
// axi_rd_arb_cnt: per-master outstanding-burst counter with limit and underflow flag.
// Rev 1.0
//============================================================================
`default_nettype none

module axi_rd_arb_cnt
  import axi_rd_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int W         = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_at_lim,
  output logic         o_err
);

  localparam logic [W-1:0] C_MAX = W'(MAX_OUTST);
  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != C_MAX) r_cnt <= r_cnt + C_ONE;
    end else if (i_dec && !i_inc) begin
      // A last beat with nothing outstanding is a slave protocol error; hold at 0.
      if (r_cnt == '0) r_err <= 1'b1;
      else             r_cnt <= r_cnt - C_ONE;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_lim = (r_cnt >= C_MAX);
  assign o_err    = r_err;

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
//============================================================================
// axi_rd_arbiter: 2:1 AXI read arbiter, round-robin AR grant, R routed by ID MSB.
// Rev 1.0
//============================================================================
`default_nettype none

module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ID_W      = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                        pll_core_cpuclk,
  input  logic                        pad_cpu_rst,
  input  logic                        m0_arvalid,
  output logic                        m0_arready,
  input  logic [ar_w(ID_W)-1:0]       m0_ar_pay,
  output logic                        m0_rvalid,
  input  logic                        m0_rready,
  output logic [r_w(ID_W)-1:0]        m0_r_pay,
  input  logic                        m1_arvalid,
  output logic                        m1_arready,
  input  logic [ar_w(ID_W)-1:0]       m1_ar_pay,
  output logic                        m1_rvalid,
  input  logic                        m1_rready,
  output logic [r_w(ID_W)-1:0]        m1_r_pay,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ar_w(ID_W+1)-1:0]     s_ar_pay,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [r_w(ID_W+1)-1:0]      s_r_pay,
  output logic [CNT_W-1:0]            m0_outst,
  output logic [CNT_W-1:0]            m1_outst
);

  localparam int AR_M_W = ar_w(ID_W);
  localparam int AR_S_W = ar_w(ID_W + 1);
  localparam int R_S_W  = r_w(ID_W + 1);
  localparam int LAST_B = r_last_bit(ID_W + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_src;
  logic                r_rr_last;
  logic [AR_S_W-1:0]   r_ar_pay;

  logic                w_lim0, w_lim1, w_err0, w_err1;
  logic                w_elig0, w_elig1;
  logic                w_gnt_any, w_gnt_src, w_s_ar_hs;
  logic [AR_M_W-1:0]   w_gnt_pay;
  logic                w_r_sel, w_r_done;

  assign w_elig0 = m0_arvalid && !w_lim0;
  assign w_elig1 = m1_arvalid && !w_lim1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_any   = 1'b0;
    w_gnt_src   = 1'b0;
    w_s_ar_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_gnt_any   = 1'b1;
          w_gnt_src   = (w_elig0 && w_elig1) ? ~r_rr_last : w_elig1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_arready) begin
          w_s_ar_hs   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_gnt_pay  = w_gnt_src ? m1_ar_pay : m0_ar_pay;
  assign m0_arready = w_gnt_any & ~w_gnt_src;
  assign m1_arready = w_gnt_any &  w_gnt_src;
  assign s_arvalid  = (r_state == ST_ISSUE);
  assign s_ar_pay   = r_ar_pay;

  // rr_last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      r_state   <= ST_IDLE;
      r_src     <= 1'b0;
      r_rr_last <= 1'b1;
      r_ar_pay  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_any) begin
        r_src    <= w_gnt_src;
        r_ar_pay <= {w_gnt_pay[AR_M_W-1:ID_W], w_gnt_src, w_gnt_pay[ID_W-1:0]};
      end
      if (w_s_ar_hs) r_rr_last <= r_src;
    end
  end

  assign w_r_sel   = s_r_pay[ID_W];
  assign m0_rvalid = s_rvalid & ~w_r_sel;
  assign m1_rvalid = s_rvalid &  w_r_sel;
  assign s_rready  = w_r_sel ? m1_rready : m0_rready;
  assign m0_r_pay  = {s_r_pay[R_S_W-1:ID_W+1], s_r_pay[ID_W-1:0]};
  assign m1_r_pay  = {s_r_pay[R_S_W-1:ID_W+1], s_r_pay[ID_W-1:0]};
  assign w_r_done  = s_rvalid & s_rready & s_r_pay[LAST_B];

  axi_rd_arb_cnt #(.MAX_OUTST(MAX_OUTST), .W(CNT_W)) u_cnt0 (
    .clk      (pll_core_cpuclk),
    .rst      (pad_cpu_rst),
    .i_inc    (w_s_ar_hs & ~r_src),
    .i_dec    (w_r_done & ~w_r_sel),
    .o_cnt    (m0_outst),
    .o_at_lim (w_lim0),
    .o_err    (w_err0)
  );

  axi_rd_arb_cnt #(.MAX_OUTST(MAX_OUTST), .W(CNT_W)) u_cnt1 (
    .clk      (pll_core_cpuclk),
    .rst      (pad_cpu_rst),
    .i_inc    (w_s_ar_hs & r_src),
    .i_dec    (w_r_done & w_r_sel),
    .o_cnt    (m1_outst),
    .o_at_lim (w_lim1),
    .o_err    (w_err1)
  );

  a_no_underflow: assert property (@(posedge pll_core_cpuclk) disable iff (pad_cpu_rst)
    !(w_err0 || w_err1));

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
//============================================================================
// tb_axi_rd_arbiter: scoreboard bench for the 2:1 AXI read arbiter.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [60:0]  m0_ar_pay;
  logic [138:0] m0_r_pay;
  logic         m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [60:0]  m1_ar_pay;
  logic [138:0] m1_r_pay;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [61:0]  s_ar_pay;
  logic [139:0] s_r_pay;
  logic [3:0]   m0_outst, m1_outst;

  int n_vec  = 0;
  int n_miss = 0;

  logic [61:0]  q_ar[$];
  logic [138:0] q_r0[$];
  logic [138:0] q_r1[$];

  logic [60:0]  p0[3];
  logic [60:0]  p1[3];
  logic [60:0]  pa, pb, pm5;
  logic [127:0] d;

  axi_rd_arbiter #(.ID_W(8), .MAX_OUTST(4)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .m0_arvalid      (m0_arvalid),
    .m0_arready      (m0_arready),
    .m0_ar_pay       (m0_ar_pay),
    .m0_rvalid       (m0_rvalid),
    .m0_rready       (m0_rready),
    .m0_r_pay        (m0_r_pay),
    .m1_arvalid      (m1_arvalid),
    .m1_arready      (m1_arready),
    .m1_ar_pay       (m1_ar_pay),
    .m1_rvalid       (m1_rvalid),
    .m1_rready       (m1_rready),
    .m1_r_pay        (m1_r_pay),
    .s_arvalid       (s_arvalid),
    .s_arready       (s_arready),
    .s_ar_pay        (s_ar_pay),
    .s_rvalid        (s_rvalid),
    .s_rready        (s_rready),
    .s_r_pay         (s_r_pay),
    .m0_outst        (m0_outst),
    .m1_outst        (m1_outst)
  );

  task automatic check(input string tag, input logic [139:0] got, input logic [139:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [60:0] mk_ar(input logic [39:0] a, input logic [7:0] len, input logic [7:0] id);
    return {a, len, 3'd4, 2'b01, id};
  endfunction

  function automatic logic [61:0] mk_sar(input logic src, input logic [60:0] p);
    return {p[60:8], src, p[7:0]};
  endfunction

  function automatic logic [139:0] mk_sr(input logic [127:0] dd, input logic [1:0] rs, input logic l, input logic [8:0] id);
    return {dd, rs, l, id};
  endfunction

  function automatic logic [138:0] mk_mr(input logic [127:0] dd, input logic [1:0] rs, input logic l, input logic [7:0] id);
    return {dd, rs, l, id};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: slave AR handshakes and master R handshakes pop expected items.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_arvalid && s_arready) begin
        if (q_ar.size() == 0) check("ar_unexpected", 140'(s_arvalid), 140'(0));
        else                  check("s_ar_pay", 140'(s_ar_pay), 140'(q_ar.pop_front()));
      end
      if (m0_rvalid && m0_rready) begin
        if (q_r0.size() == 0) check("r0_unexpected", 140'(m0_rvalid), 140'(0));
        else                  check("m0_r_pay", 140'(m0_r_pay), 140'(q_r0.pop_front()));
      end
      if (m1_rvalid && m1_rready) begin
        if (q_r1.size() == 0) check("r1_unexpected", 140'(m1_rvalid), 140'(0));
        else                  check("m1_r_pay", 140'(m1_r_pay), 140'(q_r1.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    s_rvalid   = 1'b0; s_arready  = 1'b1;
    m0_rready  = 1'b1; m1_rready  = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic ar_wait(input int m);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = (m == 0) ? m0_arready : m1_arready;
    end
    check((m == 0) ? "ar_gnt_m0" : "ar_gnt_m1", 140'(ok), 140'(1));
    cyc(1);
    if (m == 0) m0_arvalid = 1'b0;
    else        m1_arvalid = 1'b0;
  endtask

  task automatic ar_req(input int m, input logic [60:0] p);
    if (m == 0) begin m0_ar_pay = p; m0_arvalid = 1'b1; end
    else        begin m1_ar_pay = p; m1_arvalid = 1'b1; end
    ar_wait(m);
  endtask

  task automatic r_beat(input logic [139:0] p);
    logic ok;
    ok = 1'b0;
    s_r_pay  = p;
    s_rvalid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = s_rready;
    end
    check("r_handshake", 140'(ok), 140'(1));
    cyc(1);
    s_rvalid = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_ar_pay = '0; m1_ar_pay = '0;
    m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1; s_rvalid = 1'b0; s_r_pay = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_arvalid", 140'(s_arvalid), 140'(0));
    check("rst_s_ar_pay", 140'(s_ar_pay), 140'(0));
    check("rst_m0_arready", 140'(m0_arready), 140'(0));
    check("rst_m1_arready", 140'(m1_arready), 140'(0));
    check("rst_m0_outst", 140'(m0_outst), 140'(0));
    check("rst_m1_outst", 140'(m1_outst), 140'(0));
    cyc(1);
    rst = 1'b0;

    // Single master-0 burst: latency, ID tagging, R routing, counter 0->1->0.
    pa = mk_ar(40'h00_0000_1000, 8'd3, 8'h05);
    q_ar.push_back(mk_sar(1'b0, pa));
    m0_ar_pay = pa; m0_arvalid = 1'b1;
    @(negedge clk);
    check("single_m0_arready", 140'(m0_arready), 140'(1));
    check("single_no_early_s", 140'(s_arvalid), 140'(0));
    cyc(1);
    m0_arvalid = 1'b0;
    @(negedge clk);
    check("single_s_arvalid", 140'(s_arvalid), 140'(1));
    check("single_arid", 140'(s_ar_pay[8:0]), 140'(9'h005));
    cyc(1);
    check("single_outst_1", 140'(m0_outst), 140'(1));
    for (int k = 0; k < 4; k++) begin
      d = rnd128();
      q_r0.push_back(mk_mr(d, 2'(k), k == 3, 8'h05));
      r_beat(mk_sr(d, 2'(k), k == 3, 9'h005));
      if (k == 2) check("single_outst_mid", 140'(m0_outst), 140'(1));
    end
    check("single_outst_0", 140'(m0_outst), 140'(0));

    // Simultaneous requests alternate 0,1,0,1,0,1.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      p0[k] = mk_ar(40'h00_0000_2000 + 40'(k * 256), 8'd1, 8'h10 + 8'(k));
      p1[k] = mk_ar(40'h00_0008_2000 + 40'(k * 256), 8'd2, 8'h20 + 8'(k));
      q_ar.push_back(mk_sar(1'b0, p0[k]));
      q_ar.push_back(mk_sar(1'b1, p1[k]));
    end
    fork
      begin for (int k = 0; k < 3; k++) ar_req(0, p0[k]); end
      begin for (int k = 0; k < 3; k++) ar_req(1, p1[k]); end
    join
    cyc(2);
    check("alt_outst0", 140'(m0_outst), 140'(3));
    check("alt_outst1", 140'(m1_outst), 140'(3));

    // Master-1 outstanding limit.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pb = mk_ar(40'h00_0000_3000 + 40'(k * 64), 8'd0, 8'h30 + 8'(k));
      q_ar.push_back(mk_sar(1'b1, pb));
      ar_req(1, pb);
    end
    cyc(2);
    check("lim_outst1_4", 140'(m1_outst), 140'(4));
    pm5 = mk_ar(40'h00_0000_3400, 8'd0, 8'h34);
    m1_ar_pay = pm5; m1_arvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("lim_m1_blocked", 140'(m1_arready), 140'(0));
      check("lim_no_issue", 140'(s_arvalid), 140'(0));
    end
    pa = mk_ar(40'h00_0000_4000, 8'd1, 8'h40);
    q_ar.push_back(mk_sar(1'b0, pa));
    cyc(1);
    m0_ar_pay = pa; m0_arvalid = 1'b1;
    @(negedge clk);
    check("lim_m0_granted", 140'(m0_arready), 140'(1));
    check("lim_m1_held", 140'(m1_arready), 140'(0));
    cyc(1);
    m0_arvalid = 1'b0;
    cyc(2);
    check("lim_outst0_1", 140'(m0_outst), 140'(1));
    check("lim_still_held", 140'(m1_arready), 140'(0));
    q_ar.push_back(mk_sar(1'b1, pm5));
    d = rnd128();
    q_r1.push_back(mk_mr(d, 2'b00, 1'b1, 8'h30));
    r_beat(mk_sr(d, 2'b00, 1'b1, 9'h130));
    check("lim_outst1_3", 140'(m1_outst), 140'(3));
    ar_wait(1);
    cyc(2);
    check("lim_outst1_back4", 140'(m1_outst), 140'(4));

    // Slave AR stall: payload stable, no new grants, count only on handshake.
    do_reset();
    s_arready = 1'b0;
    pa = mk_ar(40'h55_0000_4000, 8'd7, 8'h5a);
    pb = mk_ar(40'h66_0000_8000, 8'd2, 8'h6b);
    q_ar.push_back(mk_sar(1'b0, pa));
    ar_req(0, pa);
    m0_ar_pay = ~pa;
    m1_ar_pay = pb; m1_arvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_arvalid", 140'(s_arvalid), 140'(1));
      check("stall_pay", 140'(s_ar_pay), 140'(mk_sar(1'b0, pa)));
      check("stall_m0_arready", 140'(m0_arready), 140'(0));
      check("stall_m1_arready", 140'(m1_arready), 140'(0));
      check("stall_outst0", 140'(m0_outst), 140'(0));
    end
    q_ar.push_back(mk_sar(1'b1, pb));
    cyc(1);
    s_arready = 1'b1;
    cyc(1);
    check("stall_outst0_after", 140'(m0_outst), 140'(1));
    ar_wait(1);
    cyc(2);
    check("stall_outst1_after", 140'(m1_outst), 140'(1));

    // Interleaved R beats and per-master ready stall.
    m1_rready = 1'b0;
    d = rnd128();
    q_r1.push_back(mk_mr(d, 2'b10, 1'b0, 8'h01));
    s_r_pay = mk_sr(d, 2'b10, 1'b0, 9'h101); s_rvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rsel1_s_rready", 140'(s_rready), 140'(0));
      check("rsel1_m1_rvalid", 140'(m1_rvalid), 140'(1));
      check("rsel1_m0_rvalid", 140'(m0_rvalid), 140'(0));
    end
    cyc(1);
    m1_rready = 1'b1;
    cyc(1);
    s_rvalid = 1'b0; m1_rready = 1'b0;
    d = rnd128();
    q_r0.push_back(mk_mr(d, 2'b00, 1'b0, 8'h07));
    s_r_pay = mk_sr(d, 2'b00, 1'b0, 9'h007); s_rvalid = 1'b1;
    @(negedge clk);
    check("rsel0_s_rready", 140'(s_rready), 140'(1));
    check("rsel0_m0_rvalid", 140'(m0_rvalid), 140'(1));
    check("rsel0_m1_rvalid", 140'(m1_rvalid), 140'(0));
    cyc(1);
    s_rvalid = 1'b0; m1_rready = 1'b1;

    // Asynchronous reset while an AR is pending in ISSUE.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pa = mk_ar(40'h00_0000_7000 + 40'(k * 128), 8'd3, 8'h70 + 8'(k));
      q_ar.push_back(mk_sar(1'b0, pa));
      ar_req(0, pa);
    end
    cyc(2);
    check("prerst_outst0", 140'(m0_outst), 140'(2));
    s_arready = 1'b0;
    ar_req(0, mk_ar(40'h00_0000_7200, 8'd0, 8'h72));
    @(negedge clk);
    check("prerst_issue", 140'(s_arvalid), 140'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_s_arvalid", 140'(s_arvalid), 140'(0));
    check("arst_s_ar_pay", 140'(s_ar_pay), 140'(0));
    check("arst_outst0", 140'(m0_outst), 140'(0));
    check("arst_outst1", 140'(m1_outst), 140'(0));
    cyc(2);
    rst = 1'b0; s_arready = 1'b1;
    pa = mk_ar(40'h00_0000_9000, 8'd0, 8'h90);
    pb = mk_ar(40'h00_0000_a000, 8'd0, 8'ha0);
    q_ar.push_back(mk_sar(1'b0, pa));
    q_ar.push_back(mk_sar(1'b1, pb));
    m0_ar_pay = pa; m0_arvalid = 1'b1;
    m1_ar_pay = pb; m1_arvalid = 1'b1;
    @(negedge clk);
    check("postrst_tie_m0", 140'(m0_arready), 140'(1));
    check("postrst_tie_m1", 140'(m1_arready), 140'(0));
    cyc(1);
    m0_arvalid = 1'b0;
    ar_wait(1);
    cyc(3);

    check("q_ar_empty", 140'(q_ar.size()), 140'(0));
    check("q_r0_empty", 140'(q_r0.size()), 140'(0));
    check("q_r1_empty", 140'(q_r1.size()), 140'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
